// File: rtl/sdram_burst_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_engine_if
//  Description : Host-command, FIFO data and SDRAM-controller signal bundle
//                for sdram_burst_engine. "slave" is the engine's view,
//                "master" is the view of the surrounding host/controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_burst_engine_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) ();
    // host command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  busy;
    logic                  done;
    // write-data FIFO input
    logic                  wdata_valid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wdata_ready;
    // read-data FIFO output
    logic                  rdata_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_ready;
    // SDRAM controller side
    logic [ADDR_WIDTH-1:0] sd_addr;
    logic                  sd_wr_enable;
    logic [DATA_WIDTH-1:0] sd_wr_data;
    logic                  sd_rd_enable;
    logic [DATA_WIDTH-1:0] sd_rd_data;
    logic                  sd_rd_ready;
    logic                  sd_busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready,
        input  sd_rd_data, sd_rd_ready, sd_busy,
        output cmd_ready, busy, done,
        output wdata_ready, rdata_valid, rdata,
        output sd_addr, sd_wr_enable, sd_wr_data, sd_rd_enable
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready,
        output sd_rd_data, sd_rd_ready, sd_busy,
        input  cmd_ready, busy, done,
        input  wdata_ready, rdata_valid, rdata,
        input  sd_addr, sd_wr_enable, sd_wr_data, sd_rd_enable
    );
endinterface
`default_nettype wire

// File: rtl/sdram_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_engine
//  Description : Turns one host command (direction, start address, byte
//                count) into a sequence of single-byte sdram_controller
//                accesses with incrementing address. Write bytes come from
//                an internal write FIFO, read bytes go to an internal
//                first-word-fall-through read FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_burst_engine #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_burst_engine_if.slave  bus
);

    localparam int                c_FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  c_FIFO_FULL  = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_WAIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    // latched command context
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]   r_remain;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic                   r_rd_seen;   // read byte of the current access already captured
    logic                   r_rd_rsv;    // read FIFO slot held for the outstanding read

    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic                   w_step;

    // write FIFO
    logic [DATA_WIDTH-1:0]  r_wf_mem [c_FIFO_DEPTH];
    logic [FIFO_AW-1:0]     r_wf_wptr;
    logic [FIFO_AW-1:0]     r_wf_rptr;
    logic [FIFO_AW:0]       r_wf_cnt;
    logic                   w_wf_empty;
    logic                   w_wf_full;
    logic                   w_wf_push;
    logic                   w_wf_pop;
    logic [DATA_WIDTH-1:0]  w_wf_head;

    // read FIFO
    logic [DATA_WIDTH-1:0]  r_rf_mem [c_FIFO_DEPTH];
    logic [FIFO_AW-1:0]     r_rf_wptr;
    logic [FIFO_AW-1:0]     r_rf_rptr;
    logic [FIFO_AW:0]       r_rf_cnt;
    logic                   w_rf_empty;
    logic                   w_rf_full;
    logic                   w_rf_push;
    logic                   w_rf_pop;
    logic [FIFO_AW:0]       w_rf_used;
    logic                   w_rf_space;

    // ------------------------------------------------------------------
    // FIFO status and handshakes. A push into a full FIFO is accepted only
    // when a pop frees a slot in the same cycle, so the count holds.
    // ------------------------------------------------------------------
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_wf_full  = (r_wf_cnt == c_FIFO_FULL);
    assign w_wf_head  = r_wf_mem[r_wf_rptr];
    assign w_wf_pop   = w_wr_en;
    assign w_wf_push  = bus.wdata_valid && (!w_wf_full || w_wf_pop);

    assign w_rf_empty = (r_rf_cnt == '0);
    assign w_rf_full  = (r_rf_cnt == c_FIFO_FULL);
    assign w_rf_pop   = bus.rdata_ready && !w_rf_empty;
    assign w_rf_push  = (r_state == S_WAIT) && !r_write && !r_rd_seen &&
                        bus.sd_rd_ready && (!w_rf_full || w_rf_pop);
    // stored bytes plus the reserved in-flight byte must leave a free slot
    assign w_rf_used  = r_rf_cnt + {{FIFO_AW{1'b0}}, r_rd_rsv};
    assign w_rf_space = (w_rf_used < c_FIFO_FULL);

    // Write FIFO storage
    always_ff @(posedge clk) begin
        if (w_wf_push) r_wf_mem[r_wf_wptr] <= bus.wdata;
    end

    // Write FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wf_wptr <= '0;
            r_wf_rptr <= '0;
            r_wf_cnt  <= '0;
        end else begin
            if (w_wf_push) r_wf_wptr <= r_wf_wptr + FIFO_AW'(1);
            if (w_wf_pop)  r_wf_rptr <= r_wf_rptr + FIFO_AW'(1);
            if (w_wf_push && !w_wf_pop)      r_wf_cnt <= r_wf_cnt + (FIFO_AW+1)'(1);
            else if (!w_wf_push && w_wf_pop) r_wf_cnt <= r_wf_cnt - (FIFO_AW+1)'(1);
        end
    end

    // Read FIFO storage
    always_ff @(posedge clk) begin
        if (w_rf_push) r_rf_mem[r_rf_wptr] <= bus.sd_rd_data;
    end

    // Read FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
            r_rf_cnt  <= '0;
        end else begin
            if (w_rf_push) r_rf_wptr <= r_rf_wptr + FIFO_AW'(1);
            if (w_rf_pop)  r_rf_rptr <= r_rf_rptr + FIFO_AW'(1);
            if (w_rf_push && !w_rf_pop)      r_rf_cnt <= r_rf_cnt + (FIFO_AW+1)'(1);
            else if (!w_rf_push && w_rf_pop) r_rf_cnt <= r_rf_cnt - (FIFO_AW+1)'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and single-cycle controller requests
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_wr_en  = 1'b0;
        w_rd_en  = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = (bus.cmd_len == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.sd_busy) begin
                    if (r_write) begin
                        if (!w_wf_empty) begin
                            w_wr_en = 1'b1;
                            w_next  = S_ACK;
                        end
                    end else if (w_rf_space) begin
                        w_rd_en = 1'b1;
                        w_next  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (bus.sd_busy) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.sd_busy && (r_write || r_rd_seen || bus.sd_rd_ready)) begin
                    w_step = 1'b1;
                    w_next = (r_remain == LEN_WIDTH'(1)) ? S_FIN : S_ISSUE;
                end
            end
            S_FIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Command context, held write byte and read-slot bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_remain  <= '0;
            r_wr_data <= '0;
            r_rd_seen <= 1'b0;
            r_rd_rsv  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= bus.cmd_write;
                r_addr    <= bus.cmd_addr;
                r_remain  <= bus.cmd_len;
                r_rd_seen <= 1'b0;
            end
            if (w_wr_en) r_wr_data <= w_wf_head;
            if (w_rd_en)        r_rd_rsv <= 1'b1;
            else if (w_rf_push) r_rd_rsv <= 1'b0;
            if (w_rf_push) r_rd_seen <= 1'b1;
            // address wraps naturally at 2^ADDR_WIDTH
            if (w_step) begin
                r_addr    <= r_addr + ADDR_WIDTH'(1);
                r_remain  <= r_remain - LEN_WIDTH'(1);
                r_rd_seen <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state == S_ISSUE) || (r_state == S_ACK) || (r_state == S_WAIT);
    assign bus.done         = (r_state == S_FIN);
    assign bus.wdata_ready  = !w_wf_full;
    assign bus.rdata_valid  = !w_rf_empty;
    assign bus.rdata        = r_rf_mem[r_rf_rptr];
    assign bus.sd_addr      = r_addr;
    assign bus.sd_wr_enable = w_wr_en;
    assign bus.sd_rd_enable = w_rd_en;
    // popped FIFO head drives the bus in the enable cycle, then is held
    assign bus.sd_wr_data   = w_wr_en ? w_wf_head : r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_burst_engine
//  Description : Directed self-checking bench for sdram_burst_engine with a
//                behavioural sdram_controller model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_engine;

    localparam int AW = 25;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sdram_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    sdram_burst_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .FIFO_AW    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // controller-model bookkeeping
    int unsigned   wr_pulses  = 0;
    int unsigned   rd_pulses  = 0;
    int unsigned   rdy_pulses = 0;
    int unsigned   done_cnt   = 0;
    int unsigned   viol       = 0;
    logic [AW-1:0] log_waddr [256];
    logic [DW-1:0] log_wdata [256];
    logic [AW-1:0] log_raddr [256];
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [7:0] bp_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // sdram_controller model: requests sampled on negedge, busy/read data
    // driven shortly after the next posedge
    initial begin : ctrl_model
        logic          pend;
        logic          cur_wr;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        int            timer;
        pend = 1'b0; cur_wr = 1'b0; p_addr = '0; p_data = '0; timer = 0;
        bus.sd_busy = 1'b0; bus.sd_rd_ready = 1'b0; bus.sd_rd_data = '0;
        for (int i = 0; i < 32; i++) mem[AW'(32'h100 + i)] = bp_byte(i);
        forever begin
            @(negedge clk);
            if (bus.sd_wr_enable && bus.sd_rd_enable) viol++;
            if ((bus.sd_wr_enable || bus.sd_rd_enable) && (pend || bus.sd_busy)) viol++;
            if (bus.done === 1'b1) done_cnt++;
            if (bus.sd_wr_enable === 1'b1) begin
                log_waddr[wr_pulses % 256] = bus.sd_addr;
                log_wdata[wr_pulses % 256] = bus.sd_wr_data;
                wr_pulses++;
                pend = 1'b1; cur_wr = 1'b1; p_addr = bus.sd_addr; p_data = bus.sd_wr_data;
            end else if (bus.sd_rd_enable === 1'b1) begin
                log_raddr[rd_pulses % 256] = bus.sd_addr;
                rd_pulses++;
                pend = 1'b1; cur_wr = 1'b0; p_addr = bus.sd_addr;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0; timer = 0; bus.sd_busy = 1'b0; bus.sd_rd_ready = 1'b0;
            end else if (pend) begin
                pend = 1'b0; bus.sd_busy = 1'b1; timer = 3;
                if (cur_wr) mem[p_addr] = p_data;
            end else if (bus.sd_busy) begin
                timer--;
                if (!cur_wr && timer == 1) begin
                    bus.sd_rd_ready = 1'b1;
                    bus.sd_rd_data  = mem.exists(p_addr) ? mem[p_addr] : 8'h00;
                    rdy_pulses++;
                end else begin
                    bus.sd_rd_ready = 1'b0;
                end
                if (timer == 0) bus.sd_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_w(input logic [7:0] b);
        bus.wdata_valid = 1'b1;
        bus.wdata       = b;
        @(negedge clk);
        bus.wdata_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_before_cmd got=%b exp=1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.sd_wr_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", bus.sd_wr_enable); end
        checks++; if (bus.sd_rd_enable !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", bus.sd_rd_enable); end
        checks++; if (bus.sd_addr !== '0) begin errors++; $display("FAIL rst_sd_addr got=%h exp=0", bus.sd_addr); end
        checks++; if (bus.sd_wr_data !== '0) begin errors++; $display("FAIL rst_sd_wr_data got=%h exp=0", bus.sd_wr_data); end
        checks++; if (bus.wdata_ready !== 1'b1) begin errors++; $display("FAIL rst_wdata_ready got=%b exp=1", bus.wdata_ready); end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_rdata_valid got=%b exp=0", bus.rdata_valid); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_write_burst();
        logic [7:0]  exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int unsigned wb, db;
        bit          seen;
        for (int i = 0; i < 4; i++) push_w(exp[i]);
        wb = wr_pulses; db = done_cnt;
        send_cmd(1'b1, 25'h0000010, 8'd4);
        wait_done(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL wr_done_timeout got=0 exp=1"); end
        tick(2);
        checks++; if (wr_pulses - wb != 4) begin errors++; $display("FAIL wr_pulse_count got=%0d exp=4", wr_pulses - wb); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_waddr[(wb + i) % 256] !== AW'(32'h10 + i) || log_wdata[(wb + i) % 256] !== exp[i]) begin
                errors++;
                $display("FAIL wr_beat%0d got=%h/%h exp=%h/%h", i, log_waddr[(wb + i) % 256],
                         log_wdata[(wb + i) % 256], AW'(32'h10 + i), exp[i]);
            end
        end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL wr_done_pulses got=%0d exp=1", done_cnt - db); end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wr_idle_after got=busy%b/ready%b exp=busy0/ready1", bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_read_burst();
        logic [7:0]  exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int unsigned rb, qb;
        bit          seen;
        bus.rdata_ready = 1'b0;
        rb = rd_pulses; qb = rdy_pulses;
        send_cmd(1'b0, 25'h0000010, 8'd4);
        wait_done(200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rd_done_timeout got=0 exp=1"); end
        checks++; if (rdy_pulses - qb != 4) begin errors++; $display("FAIL rd_done_after_4th got=%0d exp=4", rdy_pulses - qb); end
        tick(2);
        checks++; if (rd_pulses - rb != 4) begin errors++; $display("FAIL rd_pulse_count got=%0d exp=4", rd_pulses - rb); end
        checks++; if (log_raddr[(rb + 3) % 256] !== AW'(32'h13)) begin
            errors++; $display("FAIL rd_last_addr got=%h exp=13", log_raddr[(rb + 3) % 256]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.rdata_valid !== 1'b1 || bus.rdata !== exp[i]) begin
                errors++; $display("FAIL rd_data%0d got=v%b/%h exp=v1/%h", i, bus.rdata_valid, bus.rdata, exp[i]);
            end
            bus.rdata_ready = 1'b1;
            @(negedge clk);
            bus.rdata_ready = 1'b0;
        end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL rd_fifo_empty got=%b exp=0", bus.rdata_valid); end
    endtask

    task automatic test_backpressure();
        int unsigned rb, db;
        int          popped;
        bit          seen;
        bus.rdata_ready = 1'b0;
        rb = rd_pulses; db = done_cnt;
        send_cmd(1'b0, 25'h0000100, 8'd20);
        tick(150);
        checks++; if (rd_pulses - rb != 16) begin errors++; $display("FAIL bp_stall_count got=%0d exp=16", rd_pulses - rb); end
        checks++; if (bus.busy !== 1'b1 || done_cnt != db) begin
            errors++; $display("FAIL bp_still_busy got=busy%b/done%0d exp=busy1/done0", bus.busy, done_cnt - db);
        end
        checks++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== bp_byte(0)) begin
            errors++; $display("FAIL bp_head got=v%b/%h exp=v1/%h", bus.rdata_valid, bus.rdata, bp_byte(0));
        end
        bus.rdata_ready = 1'b1;
        @(negedge clk);
        bus.rdata_ready = 1'b0;
        tick(40);
        checks++; if (rd_pulses - rb != 17) begin errors++; $display("FAIL bp_one_more got=%0d exp=17", rd_pulses - rb); end
        popped = 1; seen = 1'b0;
        bus.rdata_ready = 1'b1;
        for (int c = 0; c < 400 && !(seen && popped >= 20); c++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            if (bus.rdata_valid === 1'b1) begin
                checks++;
                if (popped >= 20 || bus.rdata !== bp_byte(popped)) begin
                    errors++; $display("FAIL bp_drain%0d got=%h exp=%h", popped, bus.rdata, bp_byte(popped));
                end
                popped++;
            end
            @(negedge clk);
        end
        bus.rdata_ready = 1'b0;
        tick(2);
        checks++; if (!seen) begin errors++; $display("FAIL bp_done_timeout got=0 exp=1"); end
        checks++; if (popped != 20) begin errors++; $display("FAIL bp_popped got=%0d exp=20", popped); end
        checks++; if (rd_pulses - rb != 20) begin errors++; $display("FAIL bp_total_reads got=%0d exp=20", rd_pulses - rb); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt - db); end
    endtask

    task automatic test_write_starvation();
        int unsigned wb, db;
        wb = wr_pulses; db = done_cnt;
        send_cmd(1'b1, 25'h0000200, 8'd3);
        tick(20);
        checks++; if (wr_pulses - wb != 0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL starve_stall got=%0d/busy%b exp=0/busy1", wr_pulses - wb, bus.busy);
        end
        for (int k = 0; k < 3; k++) begin
            push_w(8'(8'hA0 + k));
            tick(15);
            checks++;
            if (wr_pulses - wb != k + 1 || log_waddr[(wb + k) % 256] !== AW'(32'h200 + k) ||
                log_wdata[(wb + k) % 256] !== 8'(8'hA0 + k)) begin
                errors++;
                $display("FAIL starve_release%0d got=%0d/%h/%h exp=%0d/%h/%h", k, wr_pulses - wb,
                         log_waddr[(wb + k) % 256], log_wdata[(wb + k) % 256], k + 1, AW'(32'h200 + k), 8'(8'hA0 + k));
            end
        end
        checks++; if (done_cnt - db != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL starve_done got=%0d/busy%b exp=1/busy0", done_cnt - db, bus.busy);
        end
    endtask

    task automatic test_wrap_noop();
        int unsigned wb, rb, db;
        bit          seen;
        push_w(8'h5A);
        push_w(8'hA5);
        wb = wr_pulses;
        send_cmd(1'b1, 25'h1FFFFFF, 8'd2);
        wait_done(100, seen);
        tick(2);
        checks++; if (!seen || wr_pulses - wb != 2) begin
            errors++; $display("FAIL wrap_count got=%0d/done%b exp=2/done1", wr_pulses - wb, seen);
        end
        checks++; if (log_waddr[wb % 256] !== 25'h1FFFFFF || log_wdata[wb % 256] !== 8'h5A) begin
            errors++; $display("FAIL wrap_first got=%h/%h exp=1ffffff/5a", log_waddr[wb % 256], log_wdata[wb % 256]);
        end
        checks++; if (log_waddr[(wb + 1) % 256] !== 25'h0000000 || log_wdata[(wb + 1) % 256] !== 8'hA5) begin
            errors++; $display("FAIL wrap_second got=%h/%h exp=0000000/a5", log_waddr[(wb + 1) % 256], log_wdata[(wb + 1) % 256]);
        end
        wb = wr_pulses; rb = rd_pulses; db = done_cnt;
        send_cmd(1'b0, 25'h0000040, 8'd0);
        seen = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL noop_done_latency got=0 exp=1"); end
        tick(3);
        checks++; if (wr_pulses != wb || rd_pulses != rb || done_cnt - db != 1 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL noop_quiet got=wr%0d/rd%0d/done%0d/ready%b exp=wr0/rd0/done1/ready1",
                               wr_pulses - wb, rd_pulses - rb, done_cnt - db, bus.cmd_ready);
        end
    endtask

    task automatic test_fifo_full();
        int unsigned wb;
        bit          seen;
        for (int i = 0; i < 16; i++) push_w(8'(8'h30 + i));
        checks++; if (bus.wdata_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.wdata_ready); end
        push_w(8'hFF);
        wb = wr_pulses;
        send_cmd(1'b1, 25'h0000300, 8'd16);
        wait_done(300, seen);
        tick(2);
        checks++; if (!seen || wr_pulses - wb != 16) begin
            errors++; $display("FAIL full_drain got=%0d/done%b exp=16/done1", wr_pulses - wb, seen);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_wdata[(wb + i) % 256] !== 8'(8'h30 + i)) begin
                errors++; $display("FAIL full_data%0d got=%h exp=%h", i, log_wdata[(wb + i) % 256], 8'(8'h30 + i));
            end
        end
        checks++; if (bus.wdata_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got=%b exp=1", bus.wdata_ready); end
        push_w(8'h77);
        wb = wr_pulses;
        send_cmd(1'b1, 25'h0000400, 8'd1);
        wait_done(100, seen);
        tick(2);
        checks++; if (!seen || wr_pulses - wb != 1 || log_wdata[wb % 256] !== 8'h77) begin
            errors++; $display("FAIL full_overflow_dropped got=%0d/%h exp=1/77", wr_pulses - wb, log_wdata[wb % 256]);
        end
    endtask

    task automatic test_reset_mid_read();
        int unsigned db, rb2;
        int          n;
        bus.rdata_ready = 1'b0;
        db = done_cnt;
        send_cmd(1'b0, 25'h0000100, 8'd4);
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            if (bus.sd_rd_enable === 1'b1) n++;
            if (n < 2) @(negedge clk);
        end
        checks++; if (n != 2) begin errors++; $display("FAIL mid_second_read got=%0d exp=2", n); end
        tick(2);
        checks++; if (bus.rdata_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", bus.rdata_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sd_rd_enable !== 1'b0 || bus.sd_wr_enable !== 1'b0) begin
            errors++; $display("FAIL mid_enables got=%b%b exp=00", bus.sd_rd_enable, bus.sd_wr_enable);
        end
        checks++; if (bus.rdata_valid !== 1'b0) begin errors++; $display("FAIL mid_rdata_valid got=%b exp=0", bus.rdata_valid); end
        tick(2);
        rst_n = 1'b1;
        rb2 = rd_pulses;
        tick(20);
        checks++; if (rd_pulses != rb2) begin errors++; $display("FAIL mid_no_more_reads got=%0d exp=0", rd_pulses - rb2); end
        checks++; if (done_cnt != db) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - db); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rdata_valid !== 1'b0) begin
            errors++; $display("FAIL mid_after_release got=ready%b/valid%b exp=ready1/valid0", bus.cmd_ready, bus.rdata_valid);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL enable_exclusive got=%0d exp=0", viol); end
    endtask

    initial begin : main
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_backpressure();
        test_write_starvation();
        test_wrap_noop();
        test_fifo_full();
        test_reset_mid_read();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
